banked_mem_ctrl: RTL and testbench
==================================

BANKED_MEM_CTRL -- requirements
Module: banked_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the total word-address width.
REQ-003 The block SHALL have parameter NUM_BANKS, default 4, meaning the number of storage banks (power of two, 1..16).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port chip_en, input, 1 bit: request qualifier; rd_en and wr_en are ignored when it is low.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-008 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-009 The block SHALL have port addr, input, ADDR_W bits: word address; the upper log2(NUM_BANKS) bits select the bank.
REQ-010 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-011 The block SHALL have port rd_data, output, DATA_W bits: read data.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: rd_data qualifier, one-cycle pulse.
REQ-013 The block SHALL have port busy, output, 1 bit: high during initialisation; all requests are ignored while it is high.
REQ-014 The block SHALL have port parity_err, output, 1 bit: present only under MEM_PARITY_EN; pulses with rd_valid.

Function
REQ-015 The FSM SHALL have states INIT and IDLE: reset enters INIT; INIT moves to IDLE after 2**ADDR_W cycles.
REQ-016 In INIT, a counter SHALL write zero, with correct parity, to one address per cycle, 0 to 2**ADDR_W-1, across all banks.
REQ-017 busy SHALL be high exactly while in INIT.
REQ-018 A write, chip_en & wr_en & !busy, SHALL update the addressed word at the same clock edge.
REQ-019 A read, chip_en & rd_en & !busy, SHALL present data on rd_data with rd_valid high exactly 2 cycles after the request edge (stage 1 bank access, stage 2 output register).
REQ-020 Reads SHALL be fully pipelined: one read per cycle is accepted, with no bubbles.
REQ-021 For rd_en and wr_en together at the same address, the read SHALL return the pre-write (old) data.
REQ-022 A read issued the cycle after a write to the same address SHALL return the new data.
REQ-023 rd_data SHALL hold its last value while rd_valid is low.
REQ-024 An address at or above NUM_BANKS*2**(ADDR_W-log2(NUM_BANKS)) cannot occur; bank indexing SHALL wrap naturally with no error logic.

Reset
REQ-025 On reset_n low, asynchronously: rd_data=0, rd_valid=0, pipeline valid bits cleared, parity_err=0, busy=1, FSM=INIT, init counter=0.
REQ-026 A reset asserted mid-INIT or mid-read SHALL discard in-flight reads (no rd_valid) and restart INIT from address 0.
REQ-027 Storage contents SHALL NOT be reset asynchronously; they are cleared only by INIT.

Configuration
REQ-028 With MEM_PARITY_EN defined, each word SHALL store one extra even-parity bit, computed on write and checked on read; parity_err SHALL equal the mismatch, aligned with rd_valid.
REQ-029 Without MEM_PARITY_EN, storage SHALL be DATA_W wide and the parity_err port SHALL be absent.

Structure
REQ-030 Package mem_pkg SHALL hold the FSM state enum (INIT, IDLE) and the function computing bank-select width from NUM_BANKS.
REQ-031 Sub-module mem_bank (single-port, synchronous write, registered read, depth 2**ADDR_W/NUM_BANKS) SHALL be instantiated NUM_BANKS times by generate.

Verification
REQ-032 Reset release -> busy high for 1024 cycles (defaults), then low; a read of any address returns 0x0000.
REQ-033 Write 0xA5A5 @0x3FF, then read @0x3FF next cycle -> rd_data=0xA5A5 with rd_valid 2 cycles after the read.
REQ-034 Back-to-back reads @0x000,0x100,0x200,0x300 after distinct writes -> four consecutive rd_valid cycles with the matching data.
REQ-035 Simultaneous rd_en/wr_en @0x010 (old 0x1111, new 0x2222) -> 0x1111 returned; a following read returns 0x2222.
REQ-036 reset_n pulsed low one cycle after a read request -> no rd_valid; busy reasserts and INIT restarts at 0.
REQ-037 MEM_PARITY_EN: force-flip one stored bit @0x005, then read -> parity_err=1 with rd_valid; unflipped reads -> parity_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the banked memory controller.
package mem_pkg;

  typedef enum logic {
    INIT,
    IDLE
  } mem_state_e;

  // Number of upper address bits needed to select one of num_banks banks.
  function automatic int unsigned bank_sel_w(input int unsigned num_banks);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      if ((32'd1 << i) < num_banks) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Single-port storage bank: synchronous write, registered read.
// A read and a write in the same cycle return the pre-write word.
module mem_bank #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [DEPTH_W-1:0] addr_i,
  input  logic [WORD_W-1:0]  wdata_i,
  output logic [WORD_W-1:0]  rdata_o
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_mem_ctrl.sv
// Banked word memory with power-up zero-fill and a 2-stage read pipeline.
// Optional even parity per word is enabled by defining MEM_PARITY_EN.
module banked_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned NUM_BANKS = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              chip_en,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
`ifdef MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned BS_W  = bank_sel_w(NUM_BANKS);
  localparam int unsigned LOC_W = ADDR_W - BS_W;
  localparam int unsigned IDX_W = (BS_W == 0) ? 1 : BS_W;
`ifdef MEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

  logic              in_init;
  logic              wr_req;
  logic              rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [IDX_W-1:0]  bank_sel;
  logic [DATA_W-1:0] wr_payload;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] bank_rdata [NUM_BANKS];
  logic [WORD_W-1:0] rd_word;

  logic              s1_valid_q;
  logic [IDX_W-1:0]  s1_bank_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              parity_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + ADDR_W'(1);
      if (init_cnt_q == '1) state_d = IDLE;
    end
  end

  assign in_init = (state_q == INIT);
  assign wr_req  = chip_en & wr_en & ~in_init;
  assign rd_req  = chip_en & rd_en & ~in_init;

  // The init counter takes over the address bus so zero-fill walks every bank.
  assign mem_addr   = in_init ? init_cnt_q : addr;
  assign wr_payload = in_init ? '0 : wr_data;

`ifdef MEM_PARITY_EN
  assign wr_word = {^wr_payload, wr_payload};
`else
  assign wr_word = wr_payload;
`endif

  if (BS_W == 0) begin : g_one_bank
    assign bank_sel = '0;
  end else begin : g_multi_bank
    assign bank_sel = mem_addr[ADDR_W-1 -: BS_W];
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel;
    assign sel = (bank_sel == IDX_W'(b));

    mem_bank #(
      .WORD_W  (WORD_W),
      .DEPTH_W (LOC_W)
    ) u_bank (
      .clk_i   (clock),
      .we_i    (sel & (in_init | wr_req)),
      .re_i    (sel & rd_req),
      .addr_i  (mem_addr[LOC_W-1:0]),
      .wdata_i (wr_word),
      .rdata_o (bank_rdata[b])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (s1_bank_q == IDX_W'(b)) rd_word = bank_rdata[b];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_bank_q    <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_req;
      if (rd_req) s1_bank_q <= bank_sel;
      rd_valid_q <= s1_valid_q;
      if (s1_valid_q) rd_data_q <= rd_word[DATA_W-1:0];
`ifdef MEM_PARITY_EN
      parity_err_q <= s1_valid_q & (^rd_word);
`else
      parity_err_q <= 1'b0;
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = in_init;
`ifdef MEM_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Randomised self-checking bench for banked_mem_ctrl against a flat-array reference model.
module tb_banked_mem_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;
  localparam int unsigned NB = 4;

  logic          clock;
  logic          reset_n;
  logic          chip_en;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
`ifdef MEM_PARITY_EN
  logic          parity_err;
`endif

  banked_mem_ctrl #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NUM_BANKS (NB)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .chip_en  (chip_en),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy)
`ifdef MEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: flat word array, countdown of remaining zero-fill cycles,
  // and a queue of read results tagged with the edge after which they appear.
  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
    logic          perr;
  } rd_exp_t;

  logic [DW-1:0] mdl_mem [2**AW];
  rd_exp_t       exp_q [$];
  int unsigned   init_left;
  int unsigned   edge_n = 0;
  logic [DW-1:0] last_data;
  int            flip_addr;

  task automatic model_reset();
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    exp_q.delete();
    last_data = '0;
    init_left = 2**AW;
    flip_addr = -1;
  endtask

  task automatic model_edge();
    edge_n++;
    if (init_left > 0) begin
      init_left--;
    end else if (chip_en) begin
      if (rd_en) exp_q.push_back('{due: edge_n + 1, data: mdl_mem[addr], perr: (int'(addr) == flip_addr)});
      if (wr_en) begin
        mdl_mem[addr] = wr_data;
        if (int'(addr) == flip_addr) flip_addr = -1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("busy", busy, init_left > 0);
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      check_eq("rd_valid", rd_valid, 1'b1);
      check_eq("rd_data", rd_data, exp_q[0].data);
`ifdef MEM_PARITY_EN
      check_eq("parity_err", parity_err, exp_q[0].perr);
`endif
      last_data = exp_q[0].data;
      void'(exp_q.pop_front());
    end else begin
      check_eq("rd_valid_idle", rd_valid, 1'b0);
      check_eq("rd_data_hold", rd_data, last_data);
`ifdef MEM_PARITY_EN
      check_eq("parity_err_idle", parity_err, 1'b0);
`endif
    end
  endtask

  // Called at a negedge: drive, let one rising edge pass, check at next negedge.
  task automatic drive(input logic ce, input logic we, input logic re,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    chip_en = ce;
    wr_en   = we;
    rd_en   = re;
    addr    = a;
    wr_data = d;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_rd_data", rd_data, '0);
    check_eq("rst_busy", busy, 1'b1);
    @(negedge clock);
    check_eq("rst_rd_valid_hold", rd_valid, 1'b0);
`ifdef MEM_PARITY_EN
    check_eq("rst_parity_err", parity_err, 1'b0);
`endif
    reset_n = 1'b1;
  endtask

  // Random requests during zero-fill must all be ignored.
  task automatic wait_init();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1100) begin
      n++;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom), DW'($urandom));
    end
    check_eq("busy_len", n, 2**AW);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chip_en = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    wr_data = '0;
    reset_n = 1'b0;
    @(negedge clock);
    apply_reset();
    wait_init();

    // Freshly initialised memory reads as zero everywhere.
    drive(1, 0, 1, 10'h000, '0);
    drive(1, 0, 1, 10'h3FF, '0);
    for (int i = 0; i < 6; i++) drive(1, 0, 1, AW'($urandom), '0);
    idle(); idle();

    // Write then read next cycle.
    drive(1, 1, 0, 10'h3FF, 16'hA5A5);
    drive(1, 0, 1, 10'h3FF, '0);
    idle(); idle();

    // Distinct writes to every bank, then back-to-back reads.
    drive(1, 1, 0, 10'h000, 16'h1000);
    drive(1, 1, 0, 10'h100, 16'h2101);
    drive(1, 1, 0, 10'h200, 16'h3202);
    drive(1, 1, 0, 10'h300, 16'h4303);
    drive(1, 0, 1, 10'h000, '0);
    drive(1, 0, 1, 10'h100, '0);
    drive(1, 0, 1, 10'h200, '0);
    drive(1, 0, 1, 10'h300, '0);
    idle(); idle();

    // Simultaneous read/write returns old data; next read sees new data.
    drive(1, 1, 0, 10'h010, 16'h1111);
    drive(1, 1, 1, 10'h010, 16'h2222);
    drive(1, 0, 1, 10'h010, '0);
    idle(); idle();

    // Requests with chip_en low are ignored.
    drive(0, 1, 0, 10'h010, 16'hDEAD);
    drive(1, 0, 1, 10'h010, '0);
    idle(); idle();

    // Random traffic over a small address pool to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7)), DW'($urandom));
    end
    idle(); idle();

`ifdef MEM_PARITY_EN
    drive(1, 1, 0, 10'h005, 16'h0F0F);
    drive(1, 1, 0, 10'h006, 16'h1234);
    idle();
    dut.g_bank[0].u_bank.mem_q[5][DW] = ~dut.g_bank[0].u_bank.mem_q[5][DW];
    flip_addr = 5;
    drive(1, 0, 1, 10'h005, '0);
    drive(1, 0, 1, 10'h006, '0);
    drive(1, 0, 1, 10'h005, '0);
    idle(); idle();
`endif

    // Reset one cycle after a read: no rd_valid, zero-fill restarts from 0.
    drive(1, 0, 1, 10'h3FF, '0);
    apply_reset();
    wait_init();
    drive(1, 0, 1, 10'h3FF, '0);
    drive(1, 0, 1, 10'h010, '0);
    drive(1, 0, 1, 10'h000, '0);
    drive(1, 0, 1, 10'h200, '0);
    idle(); idle();

    check_eq("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
